// File: rtl/demod_pkg.sv
// Shared definitions for the ternary-symbol demodulator: symbol encoding,
// symbol decode and signed 16-bit saturation.
package demod_pkg;

  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_POS  = 2'b01,
    SYM_NEG  = 2'b10,
    SYM_INV  = 2'b11
  } sym_e;

  localparam int SAMPLE_W = 16;

  // An invalid code contributes nothing to the integral; it is flagged separately.
  function automatic logic signed [1:0] sym_decode(input logic [1:0] s);
    logic signed [1:0] v;
    case (sym_e'(s))
      SYM_POS: v = 2'sb01;
      SYM_NEG: v = 2'sb11;
      default: v = 2'sb00;
    endcase
    return v;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    logic signed [15:0] r;
    if (x > 32'sd32767)       r = 16'sh7fff;
    else if (x < -32'sd32768) r = 16'sh8000;
    else                      r = x[15:0];
    return r;
  endfunction

endpackage

// File: rtl/demod_channel.sv
// One integrate-and-dump channel: accumulates decoded symbols over a window and
// on the last symbol registers the scaled, saturated Q1.15 sample.
module demod_channel
  import demod_pkg::*;
#(
  parameter int DEC_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        last,
  input  logic [1:0]  sym,
  output logic [15:0] dout,
  output logic        inv
);

  localparam int ACC_W = DEC_LOG2 + 2;
  localparam int SHIFT = 15 - DEC_LOG2;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [1:0]       sym_val;
  logic signed [31:0]      scaled;

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    sym_val = sym_decode(sym);
    inv     = (sym == SYM_INV);
    sum     = acc + {{(ACC_W-2){sym_val[1]}}, sym_val};
    scaled  = {{(32-ACC_W){sum[ACC_W-1]}}, sum} <<< SHIFT;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc  <= '0;
      dout <= '0;
    end else if (en) begin
      if (last) begin
        dout <= sat16(scaled);
        acc  <= '0;
      end else begin
        acc  <= sum;
      end
    end
  end

endmodule

// File: rtl/demodulador_hw.sv
// Three-channel ternary symbol demodulator: shared window counter, valid/err
// strobe generation and one integrate-and-dump channel per symbol stream.
module demodulador_hw
  import demod_pkg::*;
#(
  parameter int DEC_LOG2 = 8,
  parameter int OUT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       in1,
  input  logic [1:0]       in2,
  input  logic [1:0]       in3,
  output logic [OUT_W-1:0] dout1,
  output logic [OUT_W-1:0] dout2,
  output logic [OUT_W-1:0] dout3,
  output logic             valid,
  output logic             err
);

  logic [DEC_LOG2-1:0] cnt;
  logic                last;
  logic                err_acc;
  logic                inv1, inv2, inv3;
  logic                any_inv;

  always_comb begin
    last    = &cnt;
    any_inv = inv1 | inv2 | inv3;
  end

  // cnt wraps N-1 -> 0 by natural overflow; err is only set on the dump cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      err_acc <= 1'b0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= en & last;
      err   <= en & last & (err_acc | any_inv);
      if (en) begin
        cnt     <= cnt + 1'b1;
        err_acc <= last ? 1'b0 : (err_acc | any_inv);
      end
    end
  end

  demod_channel #(.DEC_LOG2(DEC_LOG2)) u_ch1 (
    .clk(clk), .rst(rst), .en(en), .last(last), .sym(in1), .dout(dout1), .inv(inv1)
  );

  demod_channel #(.DEC_LOG2(DEC_LOG2)) u_ch2 (
    .clk(clk), .rst(rst), .en(en), .last(last), .sym(in2), .dout(dout2), .inv(inv2)
  );

  demod_channel #(.DEC_LOG2(DEC_LOG2)) u_ch3 (
    .clk(clk), .rst(rst), .en(en), .last(last), .sym(in3), .dout(dout3), .inv(inv3)
  );

endmodule
